pe: RTL and testbench

Row-stationary convolution processing element for the on-chip inference array. It buffers a filter set and one ifmap row set in local scratchpads and computes 1-D convolutions across filters, channels and output columns. Each output adds a streamed input partial sum and emits the result on the opsum NoC. All four ports use enable/ready handshakes.

---
 rtl/pe_pkg.sv | 14 +
 rtl/pe_mac.sv | 46 ++++
 rtl/pe.sv | 189 ++++++++++++++++++
 tb/tb_pe.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared widths, default scratchpad depths and controller states for the PE.
// No logic here; PE_SAT_EN (handled in pe_mac) selects saturating psum arithmetic.
// Backpressure: n/a.
package pe_pkg;
    localparam int DATA_W          = 8;
    localparam int PSUM_W          = 24;
    localparam int WSPAD_DEPTH_DEF = 64;
    localparam int ISPAD_DEPTH_DEF = 16;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, IPSUM, OUT, DONE} state_t;

    localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
endpackage

// File: rtl/pe_mac.sv
// 8x8 signed multiply into a 24-bit accumulator, plus psum add and clear.
// Latency: result visible in acc one cycle after mac_en/add_en. Wraps unless PE_SAT_EN.
// Backpressure: none; the controller decides when to step.
module pe_mac
    import pe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     mac_en,
    input  logic                     add_en,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [PSUM_W-1:0] add_val,
    output logic signed [PSUM_W-1:0] acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [PSUM_W-1:0]   addend;
    logic signed [PSUM_W:0]     sum;
    logic signed [PSUM_W-1:0]   acc_nxt;

    assign prod   = w * x;
    assign addend = mac_en ? PSUM_W'(prod) : add_val;
    assign sum    = (PSUM_W+1)'(acc) + (PSUM_W+1)'(addend);

    always_comb begin
        acc_nxt = sum[PSUM_W-1:0];
`ifdef PE_SAT_EN
        // Top two sum bits disagree only on signed overflow.
        if (sum[PSUM_W] != sum[PSUM_W-1]) begin
            acc_nxt = sum[PSUM_W] ? PSUM_MIN : PSUM_MAX;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (mac_en || add_en) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/pe.sv
// Row-stationary conv PE: loads filters once and an ifmap row set per ifmap, emits F*E psums per ifmap.
// Latency: S*C MAC cycles per output, opsum_enable the cycle after the ipsum transfer. PE_SAT_EN saturates.
// Backpressure: registered readies drop after every transfer; opsum held stable while opsum_ready is low.
module pe
    import pe_pkg::*;
#(
    parameter int WSPAD_DEPTH = WSPAD_DEPTH_DEF,
    parameter int ISPAD_DEPTH = ISPAD_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] ifmap_noc,
    input  logic                     ifmap_enable,
    output logic                     ifmap_ready,
    input  logic signed [DATA_W-1:0] weight_noc,
    input  logic                     weight_enable,
    output logic                     weight_ready,
    input  logic signed [PSUM_W-1:0] ipsum_noc,
    input  logic                     ipsum_enable,
    output logic                     ipsum_ready,
    output logic signed [PSUM_W-1:0] opsum_noc,
    output logic                     opsum_enable,
    input  logic                     opsum_ready,
    input  logic [3:0]               iw_size,
    input  logic [3:0]               c,
    input  logic [3:0]               f,
    input  logic [3:0]               n,
    input  logic [3:0]               o
);
    localparam int WA = $clog2(WSPAD_DEPTH);
    localparam int IA = $clog2(ISPAD_DEPTH);

    state_t state;
    logic [3:0] cfg_s, cfg_c, cfg_f, cfg_n, cfg_o;
    logic [3:0] s_idx, ch_idx, e_idx, k_idx, n_idx;
    logic [12:0] w_cnt, i_cnt;
    logic [WA-1:0] w_ptr;
    logic [IA-1:0] i_ptr;

    logic signed [DATA_W-1:0] wspad [WSPAD_DEPTH];
    logic signed [DATA_W-1:0] ispad [ISPAD_DEPTH];
    logic signed [DATA_W-1:0] w_rd, i_rd;

    logic w_fire, i_fire, p_fire, o_fire;
    logic w_done, i_done, mac_last, mac_clr;
    logic [12:0] s_len, c_len, f_len, row_len, w_total, i_total, w_addr, i_addr;

    assign w_fire = weight_enable && weight_ready;
    assign i_fire = ifmap_enable && ifmap_ready;
    assign p_fire = ipsum_enable && ipsum_ready;
    assign o_fire = opsum_enable && opsum_ready;

    assign s_len   = 13'(cfg_s) + 13'd1;
    assign c_len   = 13'(cfg_c) + 13'd1;
    assign f_len   = 13'(cfg_f) + 13'd1;
    assign row_len = 13'(cfg_s) + 13'(cfg_o) + 13'd1;
    assign w_total = s_len * c_len * f_len;
    assign i_total = row_len * c_len;
    assign w_done  = (w_cnt == w_total);
    assign i_done  = (i_cnt == i_total);

    // Channel is the fastest index in both scratchpad layouts.
    assign w_addr = (13'(k_idx) * s_len + 13'(s_idx)) * c_len + 13'(ch_idx);
    assign i_addr = (13'(e_idx) + 13'(s_idx)) * c_len + 13'(ch_idx);
    assign w_rd   = wspad[WA'(w_addr % 13'(WSPAD_DEPTH))];
    assign i_rd   = ispad[IA'(i_addr % 13'(ISPAD_DEPTH))];

    assign mac_last = (s_idx == cfg_s) && (ch_idx == cfg_c);
    assign mac_clr  = (state == LOAD) || o_fire;

    always_ff @(posedge clk) begin
        if (w_fire) wspad[w_ptr] <= weight_noc;
        if (i_fire) ispad[i_ptr] <= ifmap_noc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cfg_s        <= '0;
            cfg_c        <= '0;
            cfg_f        <= '0;
            cfg_n        <= '0;
            cfg_o        <= '0;
            s_idx        <= '0;
            ch_idx       <= '0;
            e_idx        <= '0;
            k_idx        <= '0;
            n_idx        <= '0;
            w_cnt        <= '0;
            i_cnt        <= '0;
            w_ptr        <= '0;
            i_ptr        <= '0;
            weight_ready <= 1'b0;
            ifmap_ready  <= 1'b0;
            ipsum_ready  <= 1'b0;
            opsum_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cfg_s <= iw_size;
                    cfg_c <= c;
                    cfg_f <= f;
                    cfg_n <= n;
                    cfg_o <= o;
                    state <= LOAD;
                end
                LOAD: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 13'd1;
                        w_ptr <= (w_ptr == WA'(WSPAD_DEPTH - 1)) ? '0 : w_ptr + 1'b1;
                    end
                    if (i_fire) begin
                        i_cnt <= i_cnt + 13'd1;
                        i_ptr <= (i_ptr == IA'(ISPAD_DEPTH - 1)) ? '0 : i_ptr + 1'b1;
                    end
                    // A ready never stays high across its own transfer.
                    weight_ready <= !w_fire && !w_done;
                    ifmap_ready  <= !i_fire && !i_done;
                    if (w_done && i_done) begin
                        i_cnt  <= '0;
                        i_ptr  <= '0;
                        s_idx  <= '0;
                        ch_idx <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    if (ch_idx == cfg_c) begin
                        ch_idx <= '0;
                        s_idx  <= s_idx + 4'd1;
                    end else begin
                        ch_idx <= ch_idx + 4'd1;
                    end
                    if (mac_last) begin
                        s_idx       <= '0;
                        ipsum_ready <= 1'b1;
                        state       <= IPSUM;
                    end
                end
                IPSUM: begin
                    if (p_fire) begin
                        ipsum_ready  <= 1'b0;
                        opsum_enable <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (o_fire) begin
                        opsum_enable <= 1'b0;
                        if (e_idx == cfg_o) begin
                            e_idx <= '0;
                            if (k_idx == cfg_f) begin
                                k_idx <= '0;
                                if (n_idx == cfg_n) begin
                                    state <= DONE;
                                end else begin
                                    n_idx <= n_idx + 4'd1;
                                    state <= LOAD;
                                end
                            end else begin
                                k_idx <= k_idx + 4'd1;
                                state <= MAC;
                            end
                        end else begin
                            e_idx <= e_idx + 4'd1;
                            state <= MAC;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pe_mac u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (mac_clr),
        .mac_en  (state == MAC),
        .add_en  (p_fire),
        .w       (w_rd),
        .x       (i_rd),
        .add_val (ipsum_noc),
        .acc     (opsum_noc)
    );
endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe: feeders push expected opsums as ipsums are offered, a collector pops and compares.
module tb_pe;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic signed [7:0]  ifmap_noc, weight_noc;
    logic signed [23:0] ipsum_noc, opsum_noc;
    logic ifmap_enable, ifmap_ready, weight_enable, weight_ready;
    logic ipsum_enable, ipsum_ready, opsum_enable, opsum_ready;
    logic [3:0] iw_size, c, f, n, o;

    int n_tests = 0;
    int n_fail  = 0;
    int wv[$];
    int iv[$];
    int pv[$];
    logic signed [23:0] exp_q[$];
    logic signed [23:0] got[$];
    int  w_sent, i_sent, p_sent, total;
    bit  abort;
    int  req[8] = '{2, -22, 19, 18, -20, -18, 4, 41};

    always #5 clk = ~clk;

    pe dut (
        .clk(clk), .rst(rst),
        .ifmap_noc(ifmap_noc), .ifmap_enable(ifmap_enable), .ifmap_ready(ifmap_ready),
        .weight_noc(weight_noc), .weight_enable(weight_enable), .weight_ready(weight_ready),
        .ipsum_noc(ipsum_noc), .ipsum_enable(ipsum_enable), .ipsum_ready(ipsum_ready),
        .opsum_noc(opsum_noc), .opsum_enable(opsum_enable), .opsum_ready(opsum_ready),
        .iw_size(iw_size), .c(c), .f(f), .n(n), .o(o)
    );

    function automatic logic signed [23:0] add24(input logic signed [23:0] a, input logic signed [23:0] b);
        logic signed [24:0] s;
        s = 25'(a) + 25'(b);
`ifdef PE_SAT_EN
        if (s > 25'sd8388607) return 24'sh7FFFFF;
        if (s < -25'sd8388608) return 24'sh800000;
`endif
        return s[23:0];
    endfunction

    // Reference result for the j-th output given its ipsum.
    function automatic logic signed [23:0] model(input int j, input int ip);
        int ss, cc, ff, ee, ww, nn, k, e;
        logic signed [23:0] acc;
        ss = int'(iw_size) + 1; cc = int'(c) + 1; ff = int'(f) + 1; ee = int'(o) + 1;
        ww = ss + ee - 1;
        nn = j / (ff * ee); k = (j / ee) % ff; e = j % ee;
        acc = '0;
        for (int s = 0; s < ss; s++)
            for (int ch = 0; ch < cc; ch++)
                acc = add24(acc, 24'(wv[(k * ss + s) * cc + ch] * iv[nn * ww * cc + (e + s) * cc + ch]));
        return add24(acc, 24'(ip));
    endfunction

    task automatic set_cfg(input int a, input int b, input int d, input int e, input int g);
        iw_size = 4'(a); c = 4'(b); f = 4'(d); n = 4'(e); o = 4'(g);
    endtask

    task automatic set_base();
        set_cfg(2, 2, 1, 1, 1);
        wv = '{1, -2, 3, -1, 4, 3, 2, -3, -4, 2, -2, 1, 1, 3, 2, -4, 7, 1};
        iv = '{1, -2, 3, 2, -1, -1, 1, 1, -1, 2, 2, 4, 4, 5, 6, 2, -4, -6, 5, 3, 1, -6, 2, 3};
        pv = '{-6, -5, 11, 1, 7, 10, 20, -22};
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        weight_enable = 0; ifmap_enable = 0; ipsum_enable = 0; opsum_ready = 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic feed_w(input bit gaps);
        for (int i = 0; i < wv.size() && !abort; i++) begin
            if (gaps) begin weight_enable = 0; repeat ($urandom_range(0, 2)) @(negedge clk); end
            weight_noc = 8'(wv[i]); weight_enable = 1;
            while (!weight_ready && !abort) @(negedge clk);
            if (!abort) w_sent++;
            @(negedge clk);
        end
        weight_enable = 0;
    endtask

    task automatic feed_i(input bit gaps);
        for (int i = 0; i < iv.size() && !abort; i++) begin
            if (gaps) begin ifmap_enable = 0; repeat ($urandom_range(0, 2)) @(negedge clk); end
            ifmap_noc = 8'(iv[i]); ifmap_enable = 1;
            while (!ifmap_ready && !abort) @(negedge clk);
            if (!abort) i_sent++;
            @(negedge clk);
        end
        ifmap_enable = 0;
    endtask

    task automatic feed_p(input bit gaps);
        for (int i = 0; i < pv.size() && !abort; i++) begin
            if (gaps) begin ipsum_enable = 0; repeat ($urandom_range(0, 3)) @(negedge clk); end
            ipsum_noc = 24'(pv[i]); ipsum_enable = 1;
            while (!ipsum_ready && !abort) @(negedge clk);
            if (!abort) begin exp_q.push_back(model(i, pv[i])); p_sent++; end
            @(negedge clk);
        end
        ipsum_enable = 0;
    endtask

    task automatic collect(input bit gaps, input bit stall);
        int cyc = 0;
        int stall_left = stall ? 3 : 0;
        logic signed [23:0] held = '0;
        logic signed [23:0] e;
        while (got.size() < total && cyc < 5000) begin
            @(negedge clk); cyc++;
            if (stall_left == 3 && opsum_enable) begin
                held = opsum_noc; opsum_ready = 0; stall_left--;
            end else if (stall_left == 1 || stall_left == 2) begin
                n_tests++;
                if (opsum_enable !== 1'b1 || opsum_noc !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: enable %b data %0d, want enable 1 data %0d", opsum_enable, opsum_noc, held);
                end
                opsum_ready = 0; stall_left--;
            end else begin
                opsum_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (opsum_enable && opsum_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard: unexpected opsum %0d, want none", opsum_noc);
                end else begin
                    e = exp_q.pop_front();
                    if (opsum_noc !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard[%0d]: got %0d, want %0d", got.size(), opsum_noc, e);
                    end
                end
                got.push_back(opsum_noc);
            end
        end
        n_tests++;
        if (got.size() < total) begin
            n_fail++;
            $display("FAIL collect_timeout: got %0d opsums, want %0d", got.size(), total);
        end
        abort = 1;
        opsum_ready = 1;
    endtask

    task automatic run_stream(input bit gaps, input bit stall);
        abort = 0; exp_q.delete(); got.delete();
        w_sent = 0; i_sent = 0; p_sent = 0;
        total = (int'(f) + 1) * (int'(n) + 1) * (int'(o) + 1);
        fork
            feed_w(gaps);
            feed_i(gaps);
            feed_p(gaps);
            collect(gaps, stall);
        join
        n_tests++;
        if (w_sent != wv.size() || i_sent != iv.size() || p_sent != pv.size()) begin
            n_fail++;
            $display("FAIL transfer_counts: w %0d i %0d p %0d, want %0d %0d %0d",
                     w_sent, i_sent, p_sent, wv.size(), iv.size(), pv.size());
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expected opsums never produced, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        set_base();
        rst = 1'b0;
        weight_enable = 1; ifmap_enable = 1; ipsum_enable = 1; opsum_ready = 1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({weight_ready, ifmap_ready, ipsum_ready, opsum_enable} !== 4'b0 || opsum_noc !== 24'sd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy w/i/p %b%b%b en %b data %0d, want all 0",
                     weight_ready, ifmap_ready, ipsum_ready, opsum_enable, opsum_noc);
        end
    endtask

    task automatic test_baseline();
        set_base(); apply_reset(); run_stream(0, 0);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== 24'(req[i])) begin
                n_fail++;
                $display("FAIL baseline_ref[%0d]: got %0d, want %0d", i, (i < got.size()) ? got[i] : 'x, req[i]);
            end
        end
    endtask

    task automatic test_gaps();
        set_base(); apply_reset(); run_stream(1, 0);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== 24'(req[i])) begin
                n_fail++;
                $display("FAIL gaps_ref[%0d]: got %0d, want %0d", i, (i < got.size()) ? got[i] : 'x, req[i]);
            end
        end
    endtask

    task automatic test_stall();
        set_base(); apply_reset(); run_stream(0, 1);
        n_tests++;
        if (got.size() != 8 || got[0] !== 24'(req[0])) begin
            n_fail++;
            $display("FAIL stall_result: got %0d outputs first %0d, want 8 first %0d",
                     got.size(), (got.size() > 0) ? got[0] : 'x, req[0]);
        end
    endtask

    task automatic test_minimal();
        int t;
        set_cfg(0, 0, 0, 0, 0); wv = '{3}; iv = '{-4}; pv = '{5};
        apply_reset();
        opsum_ready = 0;
        weight_noc = 3; ifmap_noc = -4; weight_enable = 1; ifmap_enable = 1;
        t = 0;
        while (!(weight_ready && ifmap_ready) && t < 50) begin @(negedge clk); t++; end
        n_tests++;
        if (t >= 50) begin n_fail++; $display("FAIL min_load_ready: ready never rose within %0d cycles", t); end
        @(negedge clk);
        n_tests++;
        if ({weight_ready, ifmap_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL min_ready_drop: w %b i %b, want 0 0", weight_ready, ifmap_ready);
        end
        ipsum_noc = 5; ipsum_enable = 1; t = 0;
        while (!ipsum_ready && t < 50) begin @(negedge clk); t++; end
        n_tests++;
        if (t >= 50) begin n_fail++; $display("FAIL min_ipsum_ready: never rose within %0d cycles", t); end
        @(negedge clk);
        ipsum_enable = 0;
        n_tests++;
        if (opsum_enable !== 1'b1 || opsum_noc !== -24'sd7) begin
            n_fail++;
            $display("FAIL min_opsum: enable %b data %0d, want 1 -7", opsum_enable, opsum_noc);
        end
        n_tests++;
        if (ipsum_ready !== 1'b0) begin n_fail++; $display("FAIL min_ipsum_drop: ready %b, want 0", ipsum_ready); end
        opsum_ready = 1;
        @(negedge clk);
        n_tests++;
        if (opsum_enable !== 1'b0) begin n_fail++; $display("FAIL min_opsum_drop: enable %b, want 0", opsum_enable); end
        weight_enable = 1; ifmap_enable = 1; ipsum_enable = 1;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({weight_ready, ifmap_ready, ipsum_ready, opsum_enable} !== 4'b0) begin
            n_fail++;
            $display("FAIL done_quiet: rdy w/i/p %b%b%b en %b, want all 0", weight_ready, ifmap_ready, ipsum_ready, opsum_enable);
        end
        weight_enable = 0; ifmap_enable = 0; ipsum_enable = 0;
    endtask

    task automatic test_saturation();
        logic signed [23:0] want;
`ifdef PE_SAT_EN
        want = 24'sh7FFFFF;
`else
        want = 24'sh800000;
`endif
        set_cfg(0, 0, 0, 0, 0); wv = '{1}; iv = '{1}; pv = '{8388607};
        apply_reset(); run_stream(0, 0);
        n_tests++;
        if (got.size() != 1 || got[0] !== want) begin
            n_fail++;
            $display("FAIL saturation: got %0d (%0d outputs), want %0d", (got.size() > 0) ? got[0] : 'x, got.size(), want);
        end
    endtask

    task automatic test_reset_mid_mac();
        int t;
        set_base(); apply_reset();
        abort = 0; w_sent = 0; i_sent = 0;
        fork
            feed_w(0);
            feed_i(0);
            begin
                t = 0;
                while (dut.state != MAC && t < 500) begin @(negedge clk); t++; end
                n_tests++;
                if (t >= 500) begin n_fail++; $display("FAIL mid_mac_reach: MAC not reached in %0d cycles", t); end
                rst = 1'b0;
                @(negedge clk);
                n_tests++;
                if ({weight_ready, ifmap_ready, ipsum_ready, opsum_enable} !== 4'b0 || opsum_noc !== 24'sd0) begin
                    n_fail++;
                    $display("FAIL mid_mac_reset: rdy w/i/p %b%b%b en %b data %0d, want all 0",
                             weight_ready, ifmap_ready, ipsum_ready, opsum_enable, opsum_noc);
                end
                abort = 1;
            end
        join
        apply_reset(); run_stream(0, 0);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (i >= got.size() || got[i] !== 24'(req[i])) begin
                n_fail++;
                $display("FAIL rerun_ref[%0d]: got %0d, want %0d", i, (i < got.size()) ? got[i] : 'x, req[i]);
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        weight_enable = 0; ifmap_enable = 0; ipsum_enable = 0; opsum_ready = 1;
        weight_noc = 0; ifmap_noc = 0; ipsum_noc = 0;
        set_cfg(0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_baseline();
        test_gaps();
        test_stall();
        test_minimal();
        test_saturation();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
